// File: rtl/sram_responder_if.sv
// SRAM pin bundle driven by the SramController toward the responder.
// The data bus SRAM_DQ is bidirectional and travels beside this bundle
// as its own inout net.
//
// Pin protocol: every pin is sampled on the rising clock edge. A cycle
// with CE_N=0 and WE_N=0 is a write, and the controller drives DQ during
// that cycle. A cycle with CE_N=0, WE_N=1 and OE_N=0 is a read-address
// sample. Any other combination is idle. The responder drives DQ only
// while a pipelined read result is due and the pins still request a read.
interface sram_responder_if #(
   parameter int ADDR_W = 18
);
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_WE_N;
   logic              SRAM_CE_N;
   logic              SRAM_OE_N;
   logic              SRAM_UB_N;
   logic              SRAM_LB_N;

   modport master (
      output SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
   );

   modport slave (
      input SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
   );
endinterface

// File: rtl/sram_responder.sv
// Clocked model of a 16-bit external SRAM. It answers the controller's pin
// interface, stores byte-laned writes and returns read data READ_LAT cycles
// after the address is sampled. Access counters and a sticky out-of-range
// flag are exposed. dq_oe shows the per-lane bus drive ({upper, lower}).
//
// Optional build macro SRAM_RESPONDER_SCRUB_EN: after reset a scrub FSM
// zeroes every word, one per cycle, and the pins are ignored until it
// finishes. init_busy reflects the scrub FSM state (1 = SCRUB).
module sram_responder #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   sram_responder_if.slave   sram,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic [31:0]       wr_count,
   output logic [31:0]       rd_count,
   output logic              oob_err,
   output logic              init_busy,
   output logic [1:0]        dq_oe
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TAIL  = READ_LAT - 1;
   localparam int HALF  = DATA_W / 2;

   logic [DATA_W-1:0]                mem [DEPTH];
   logic                             is_wr;
   logic                             is_rd;
   logic                             in_range;
   logic [IDX_W-1:0]                 idx;
   logic                             scrub_we;
   logic [IDX_W-1:0]                 scrub_addr;
   logic [READ_LAT-1:0]              pipe_vld;
   logic [READ_LAT-1:0]              pipe_ub_n;
   logic [READ_LAT-1:0]              pipe_lb_n;
   logic [READ_LAT-1:0][DATA_W-1:0]  pipe_data;
   logic                             drive;

   // Cycle classification; pins are ignored while the scrub runs.
   assign is_wr    = !init_busy && !sram.SRAM_CE_N && !sram.SRAM_WE_N;
   assign is_rd    = !init_busy && !sram.SRAM_CE_N && sram.SRAM_WE_N && !sram.SRAM_OE_N;
   assign in_range = {{(32-ADDR_W){1'b0}}, sram.SRAM_ADDR} < 32'(DEPTH);
   assign idx      = sram.SRAM_ADDR[IDX_W-1:0];

`ifdef SRAM_RESPONDER_SCRUB_EN
   typedef enum logic {SCRUB, READY} scrub_state_t;

   scrub_state_t     state;
   scrub_state_t     state_nxt;
   logic [IDX_W-1:0] scrub_addr_nxt;

   // Scrub state register; reset restarts the sweep at address 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= SCRUB;
         scrub_addr <= '0;
      end else begin
         state      <= state_nxt;
         scrub_addr <= scrub_addr_nxt;
      end
   end

   // One zero write per cycle; leave SCRUB after the last word is written.
   always_comb begin
      state_nxt      = state;
      scrub_addr_nxt = scrub_addr;
      scrub_we       = 1'b0;
      init_busy      = 1'b0;
      case (state)
         SCRUB: begin
            init_busy = 1'b1;
            scrub_we  = 1'b1;
            if (scrub_addr == IDX_W'(DEPTH - 1)) begin
               state_nxt = READY;
            end else begin
               scrub_addr_nxt = scrub_addr + 1'b1;
            end
         end
         default: ;
      endcase
   end
`else
   assign init_busy  = 1'b0;
   assign scrub_we   = 1'b0;
   assign scrub_addr = '0;
`endif

   // Storage: scrub zeroing, else byte-laned pin writes to in-range words.
   always_ff @(posedge clk) begin
      if (scrub_we) begin
         mem[scrub_addr] <= '0;
      end else if (is_wr && in_range) begin
         if (!sram.SRAM_UB_N) mem[idx][DATA_W-1:HALF] <= SRAM_DQ[DATA_W-1:HALF];
         if (!sram.SRAM_LB_N) mem[idx][HALF-1:0]      <= SRAM_DQ[HALF-1:0];
      end
   end

   // Read data captured at the sample edge (pre-write contents), then delayed.
   always_ff @(posedge clk) begin
      pipe_data[0] <= in_range ? mem[idx] : '0;
      for (int i = 1; i < READ_LAT; i++) pipe_data[i] <= pipe_data[i-1];
   end

   // Read pipeline valid and lane enables; reset flushes it immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld  <= '0;
         pipe_ub_n <= '1;
         pipe_lb_n <= '1;
      end else begin
         pipe_vld[0]  <= is_rd;
         pipe_ub_n[0] <= sram.SRAM_UB_N;
         pipe_lb_n[0] <= sram.SRAM_LB_N;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_ub_n[i] <= pipe_ub_n[i-1];
            pipe_lb_n[i] <= pipe_lb_n[i-1];
         end
      end
   end

   // Saturating access counters and the sticky out-of-range flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_count <= '0;
         rd_count <= '0;
         oob_err  <= 1'b0;
      end else begin
         if (is_wr && (wr_count != 32'hFFFF_FFFF)) wr_count <= wr_count + 32'd1;
         if (is_rd && (rd_count != 32'hFFFF_FFFF)) rd_count <= rd_count + 32'd1;
         if ((is_wr || is_rd) && !in_range) oob_err <= 1'b1;
      end
   end

   // Drive only while a result is due and the pins still ask for a read.
   assign drive = pipe_vld[TAIL] && !sram.SRAM_CE_N && !sram.SRAM_OE_N && sram.SRAM_WE_N;
   assign dq_oe = {drive && !pipe_ub_n[TAIL], drive && !pipe_lb_n[TAIL]};

   assign SRAM_DQ[DATA_W-1:HALF] = dq_oe[1] ? pipe_data[TAIL][DATA_W-1:HALF] : {HALF{1'bz}};
   assign SRAM_DQ[HALF-1:0]      = dq_oe[0] ? pipe_data[TAIL][HALF-1:0]      : {HALF{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed scenarios with literal expectations plus
// randomized pin traffic, all checked every cycle against a behavioural model
// (word array with lane-known bits, queue of due read results).
module tb_sram_responder;
   localparam int ADDR_W   = 18;
   localparam int DATA_W   = 16;
   localparam int DEPTH    = 1024;
   localparam int READ_LAT = 1;
`ifdef SRAM_RESPONDER_SCRUB_EN
   localparam int SCRUB_ON = 1;
`else
   localparam int SCRUB_ON = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sram_responder_if #(.ADDR_W(ADDR_W)) bus ();
   wire  [DATA_W-1:0] SRAM_DQ;
   logic [DATA_W-1:0] tb_dq    = '0;
   logic              tb_dq_en = 1'b0;
   assign SRAM_DQ = tb_dq_en ? tb_dq : {DATA_W{1'bz}};

   logic [31:0] wr_count;
   logic [31:0] rd_count;
   logic        oob_err;
   logic        init_busy;
   logic [1:0]  dq_oe;

   sram_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst(rst), .sram(bus), .SRAM_DQ(SRAM_DQ),
      .wr_count(wr_count), .rd_count(rd_count), .oob_err(oob_err),
      .init_busy(init_busy), .dq_oe(dq_oe)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model / scoreboard ----------------
   typedef struct {
      int          due;
      logic [15:0] data;
      logic [1:0]  en;
      logic [1:0]  known;
   } rd_t;

   rd_t         exp_q[$];
   logic [15:0] m_mem   [DEPTH];
   logic [1:0]  m_known [DEPTH];
   int unsigned m_wr = 0;
   int unsigned m_rd = 0;
   bit          m_oob = 1'b0;
   int          scrub_cnt = (SCRUB_ON != 0) ? 0 : DEPTH;
   int          cyc = 0;
   bit          chk_en = 1'b0;

   initial for (int i = 0; i < DEPTH; i++) m_known[i] = 2'b00;

   // Reset clears everything the model tracks except the array.
   always @(negedge rst) begin
      exp_q.delete();
      m_wr      = 0;
      m_rd      = 0;
      m_oob     = 1'b0;
      scrub_cnt = (SCRUB_ON != 0) ? 0 : DEPTH;
   end

   // Apply each edge's pin activity to the model.
   always @(posedge clk) begin : model_p
      rd_t r;
      int  a;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      a = int'(bus.SRAM_ADDR);
      if (!rst) begin
         exp_q.delete();
         scrub_cnt = (SCRUB_ON != 0) ? 0 : DEPTH;
      end else if (scrub_cnt < DEPTH) begin
         m_mem[scrub_cnt]   = 16'h0000;
         m_known[scrub_cnt] = 2'b11;
         scrub_cnt++;
      end else if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) begin
         if (m_wr != 32'hFFFF_FFFF) m_wr++;
         if (a >= DEPTH) m_oob = 1'b1;
         else begin
            if (!bus.SRAM_UB_N) begin m_mem[a][15:8] = tb_dq[15:8]; m_known[a][1] = 1'b1; end
            if (!bus.SRAM_LB_N) begin m_mem[a][7:0]  = tb_dq[7:0];  m_known[a][0] = 1'b1; end
         end
      end else if (!bus.SRAM_CE_N && !bus.SRAM_OE_N) begin
         if (m_rd != 32'hFFFF_FFFF) m_rd++;
         r.due = cyc + READ_LAT - 1;
         r.en  = {!bus.SRAM_UB_N, !bus.SRAM_LB_N};
         if (a >= DEPTH) begin
            m_oob   = 1'b1;
            r.data  = 16'h0000;
            r.known = 2'b11;
         end else begin
            r.data  = m_mem[a];
            r.known = m_known[a];
         end
         exp_q.push_back(r);
      end
   end

   // Per-cycle compare, mid-cycle away from the active edge.
   always @(negedge clk) begin : compare_p
      logic [1:0] e_oe;
      rd_t        r;
      bit         hit;
      if (chk_en) begin
         e_oe = 2'b00;
         hit  = 1'b0;
         if (rst && exp_q.size() > 0 && exp_q[0].due == cyc &&
             !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N) begin
            r    = exp_q[0];
            hit  = 1'b1;
            e_oe = r.en;
         end
         check("dq_oe", 32'(dq_oe), 32'(e_oe));
         if (hit && e_oe[1] && r.known[1]) check("dq_hi", 32'(SRAM_DQ[15:8]), 32'(r.data[15:8]));
         if (hit && e_oe[0] && r.known[0]) check("dq_lo", 32'(SRAM_DQ[7:0]), 32'(r.data[7:0]));
         check("wr_count", wr_count, m_wr);
         check("rd_count", rd_count, m_rd);
         check("oob_err", 32'(oob_err), 32'(m_oob));
         check("init_busy", 32'(init_busy), 32'(scrub_cnt < DEPTH));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit ce_n, input bit we_n, input bit oe_n, input bit ub_n,
                        input bit lb_n, input logic [17:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      bus.SRAM_CE_N = ce_n;
      bus.SRAM_WE_N = we_n;
      bus.SRAM_OE_N = oe_n;
      bus.SRAM_UB_N = ub_n;
      bus.SRAM_LB_N = lb_n;
      bus.SRAM_ADDR = a;
      tb_dq         = d;
      tb_dq_en      = !ce_n && !we_n;
   endtask

   task automatic pins_idle_now();
      bus.SRAM_CE_N = 1'b1;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b1;
      bus.SRAM_UB_N = 1'b1;
      bus.SRAM_LB_N = 1'b1;
      bus.SRAM_ADDR = '0;
      tb_dq_en      = 1'b0;
   endtask

   task automatic wr(input logic [17:0] a, input logic [15:0] d, input bit ub_n, input bit lb_n);
      drive(1'b0, 1'b0, 1'b1, ub_n, lb_n, a, d);
   endtask

   task automatic rdp(input logic [17:0] a, input bit ub_n, input bit lb_n);
      drive(1'b0, 1'b1, 1'b0, ub_n, lb_n, a, 16'h0000);
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0000);
   endtask

   // Present a read, keep OE asserted through the latency, sample in the data cycle.
   task automatic rd_sample(input logic [17:0] a, input bit ub_n, input bit lb_n,
                            output logic [15:0] q, output logic [1:0] oe);
      rdp(a, ub_n, lb_n);
      repeat (READ_LAT) rdp(a, ub_n, lb_n);
      @(negedge clk);
      q  = SRAM_DQ;
      oe = dq_oe;
   endtask

   task automatic hold_reset_then_release();
      rst = 1'b0;
      pins_idle_now();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < DEPTH + 20; i++) begin
         if (!init_busy) break;
         @(negedge clk);
      end
      check("ready_timeout", 32'(init_busy), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] q;
   logic [15:0] q_hi;
   logic [1:0]  oe;

   initial begin
      pins_idle_now();
      chk_en = 1'b1;
      hold_reset_then_release();
      check("rst_wr_count", wr_count, 32'd0);
      check("rst_rd_count", rd_count, 32'd0);
      check("rst_oob", 32'(oob_err), 32'd0);
      check("rst_dq_oe", 32'(dq_oe), 32'd0);

`ifdef SRAM_RESPONDER_SCRUB_EN
      begin : scrub_test
         int busy_cycles;
         busy_cycles = init_busy ? 1 : 0;
         for (int g = 0; g < DEPTH + 20; g++) begin
            wr(18'h5, 16'h1234, 1'b0, 1'b0);
            @(negedge clk);
            if (!init_busy) break;
            busy_cycles++;
         end
         #1 pins_idle_now();
         check("scrub_busy_cycles", 32'(busy_cycles), 32'(DEPTH));
         check("scrub_writes_ignored", wr_count, 32'd0);
         for (int i = 0; i < DEPTH; i++) rdp(18'(i), 1'b0, 1'b0);
         idle();
         rd_sample(18'h5, 1'b0, 1'b0, q, oe);
         check("scrub_addr5_zero", 32'(q), 32'h0000);
         hold_reset_then_release();
         wait_ready();
      end
`endif

      // Basic write then read.
      wr(18'h10, 16'hBEEF, 1'b0, 1'b0);
      rd_sample(18'h10, 1'b0, 1'b0, q, oe);
      check("t1_data", 32'(q), 32'h0000_BEEF);
      check("t1_oe", 32'(oe), 32'd3);
      check("t1_wr_count", wr_count, 32'd1);
      check("t1_rd_count", rd_count, 32'd1);

      // Byte-lane write merge and lane-masked read.
      wr(18'h20, 16'hBEEF, 1'b0, 1'b0);
      wr(18'h20, 16'h1234, 1'b1, 1'b0);
      rd_sample(18'h20, 1'b0, 1'b0, q, oe);
      check("t2_merge", 32'(q), 32'h0000_BE34);
      rd_sample(18'h20, 1'b0, 1'b1, q, oe);
      check("t2_lb_off_oe", 32'(oe), 32'd2);
      check("t2_lb_off_hi", 32'(q[15:8]), 32'h0000_00BE);

      // Two-word controller transfer.
      wr(18'h0, 16'hF00D, 1'b0, 1'b0);
      wr(18'h1, 16'hCAFE, 1'b0, 1'b0);
      rd_sample(18'h0, 1'b0, 1'b0, q, oe);
      rd_sample(18'h1, 1'b0, 1'b0, q_hi, oe);
      check("t3_word32", {q_hi, q}, 32'hCAFE_F00D);

      // Old/new data around a write, and no drive while WE_N=0.
      wr(18'h3, 16'hAAAA, 1'b0, 1'b0);
      rd_sample(18'h3, 1'b0, 1'b0, q, oe);
      check("t4_old", 32'(q), 32'h0000_AAAA);
      rdp(18'h3, 1'b0, 1'b0);
      wr(18'h3, 16'h5555, 1'b0, 1'b0);
      @(negedge clk);
      check("t4_no_drive_we", 32'(dq_oe), 32'd0);
      rd_sample(18'h3, 1'b0, 1'b0, q, oe);
      check("t4_new", 32'(q), 32'h0000_5555);

      // Out-of-range read, sticky flag, reset mid-read.
      idle();
      rd_sample(18'(DEPTH), 1'b0, 1'b0, q, oe);
      check("t5_oob_data", 32'(q), 32'h0000_0000);
      check("t5_oob_oe", 32'(oe), 32'd3);
      check("t5_oob_flag", 32'(oob_err), 32'd1);
      repeat (3) idle();
      @(negedge clk);
      check("t5_oob_sticky", 32'(oob_err), 32'd1);
      rdp(18'(DEPTH), 1'b0, 1'b0);
      rdp(18'(DEPTH), 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("t5_pre_rst_oe", 32'(dq_oe), 32'd3);
      rst = 1'b0;
      #1;
      check("t5_rst_release_dq", 32'(dq_oe), 32'd0);
      check("t5_rst_oob", 32'(oob_err), 32'd0);
      check("t5_rst_rd_count", rd_count, 32'd0);
      hold_reset_then_release();
      wait_ready();

      // Randomized traffic against the model.
      for (int i = 0; i < 16; i++) wr(18'(i), 16'($urandom), 1'b0, 1'b0);
      for (int i = DEPTH - 16; i < DEPTH; i++) wr(18'(i), 16'($urandom), 1'b0, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         logic [17:0] a;
         int          kind;
         bit          ub_n;
         bit          lb_n;
         case ($urandom_range(0, 3))
            0:       a = 18'($urandom_range(0, 15));
            1:       a = 18'($urandom_range(DEPTH - 16, DEPTH + 7));
            2:       a = 18'($urandom_range(0, DEPTH - 1));
            default: a = 18'($urandom_range(0, (1 << ADDR_W) - 1));
         endcase
         ub_n = ($urandom_range(0, 3) == 0);
         lb_n = ($urandom_range(0, 3) == 0);
         kind = $urandom_range(0, 9);
         if (kind <= 3)      wr(a, 16'($urandom), ub_n, lb_n);
         else if (kind <= 7) rdp(a, ub_n, lb_n);
         else if (kind == 8) idle();
         else drive(1'($urandom), 1'($urandom), 1'($urandom), ub_n, lb_n, a, 16'($urandom));
      end
      repeat (4) idle();
      @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      fails++;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Clocked, synthesizable model of the 16-bit external SRAM chip. It is the responder end of the SRAM pin interface that the SramController drives.
- Used in simulation and FPGA loopback builds to close the memory path without the physical chip.
- It decodes SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N and SRAM_LB_N, stores byte-laned writes, and returns read data on SRAM_DQ after a fixed pipeline latency.
- It also exposes access counters and error flags for benches.

Parameters:
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: data bus width. Must be 16; lanes are [15:8] (UB) and [7:0] (LB).
- DEPTH, 1024: number of implemented words. Addresses >= DEPTH are out of range.
- READ_LAT, 1: cycles from read-address sample to data on SRAM_DQ. Legal range 1..4.

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- SRAM_DQ  inout  16  bidirectional data bus; driven only per the read rules, otherwise high-Z.
- SRAM_ADDR  in  18  word address.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- SRAM_UB_N  in  1  upper byte enable, active-low.
- SRAM_LB_N  in  1  lower byte enable, active-low.
- wr_count  out  32  number of accepted write cycles.
- rd_count  out  32  number of accepted read-address samples.
- oob_err  out  1  sticky; set on any access with SRAM_ADDR >= DEPTH.
- init_busy  out  1  scrub in progress (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - wr_count=0, rd_count=0, oob_err=0.
  - Read pipeline valid bits cleared; SRAM_DQ high-Z.
  - Memory array is not cleared (except by the optional scrub).
- Cycle classification, at posedge clk with init_busy=0:
  - WRITE: CE_N=0 and WE_N=0.
  - READ: CE_N=0, WE_N=1, OE_N=0.
  - IDLE: anything else.
- WRITE:
  - If ADDR < DEPTH: mem[ADDR][15:8] <= DQ[15:8] if UB_N=0; mem[ADDR][7:0] <= DQ[7:0] if LB_N=0.
  - If UB_N=LB_N=1: no array change, but the write is still counted.
  - wr_count increments, saturating at 32'hFFFFFFFF.
  - Write has priority over OE_N.
- READ:
  - ADDR and the lane enables are pushed into a READ_LAT-deep pipeline with a valid bit.
  - rd_count increments, saturating.
- Out-of-range access (WRITE or READ with ADDR >= DEPTH):
  - oob_err set; array untouched.
  - A read returns 16'h0000 on enabled lanes.
- DQ drive:
  - SRAM_DQ is driven only when the pipeline tail is valid AND current CE_N=0, OE_N=0, WE_N=1.
  - Value: mem[tail addr], using array contents at the sample edge.
  - Lanes whose captured UB_N/LB_N was 1 are driven Z; all other times the bus is high-Z.
  - The bus must never drive during a cycle with WE_N=0.
- Read-after-write:
  - A read sampled on the same edge as a write to the same address returns the old data.
  - A read sampled the edge after the write returns the new data.
- Latency:
  - With READ_LAT=1, an address presented in cycle k (controller state 001) yields data during cycle k+1 (state 010).
  - Back-to-back reads are fully pipelined: one word per cycle.
- Reset mid-read: pipeline flushed; DQ releases to Z asynchronously.
- oob_err clears only on reset.

Optional Feature:
- Macro: SRAM_RESPONDER_SCRUB_EN.
- Enabled:
  - On reset release, a scrub FSM (SCRUB -> READY) writes 16'h0000 to addresses 0..DEPTH-1, one word per cycle.
  - init_busy=1 from reset through the final scrub write, and drops the cycle after address DEPTH-1 is written.
  - While init_busy=1, pin accesses are ignored: no writes, no pipeline push, no counting, DQ high-Z.
  - Reset during scrub restarts it at address 0.
- Disabled:
  - init_busy is tied 0 and the array powers up uninitialised (X in simulation).

Test Plan:
- Write ADDR=18'h10, DQ=16'hBEEF, UB_N=LB_N=0, then read ADDR=18'h10 -> DQ=16'hBEEF exactly READ_LAT cycles later; wr_count=1, rd_count=1.
- Write 16'hBEEF to 18'h20; write 16'h1234 to 18'h20 with UB_N=1; read 18'h20 -> 16'hBE34. Read with LB_N=1 -> DQ[7:0]=Z, DQ[15:8]=8'hBE.
- Controller 32-bit write of 32'hCAFE_F00D at ALU_Res=1024, then read -> mem[0]=16'hF00D, mem[1]=16'hCAFE; controller readData=32'hCAFEF00D with ready asserted.
- Read ADDR=DEPTH (1024) -> oob_err=1 and stays 1; DQ=16'h0000. Assert rst=0 mid-read -> DQ goes Z immediately and oob_err=0.
- Same edge: write 16'h5555 and read-sample at 18'h3 (old value 16'hAAAA) via two-phase stimulus -> 16'hAAAA returned; next read -> 16'h5555. Check DQ is Z throughout WE_N=0 cycles.
- With SRAM_RESPONDER_SCRUB_EN and DEPTH=16: init_busy high for 16 cycles after reset release; writes during busy are ignored; afterwards reads of every address return 16'h0000.
